// File: rtl/uart_channel_router.sv
// uart_channel_router: routes one host UART to one of N_CH channel UARTs.
// Channel changes are requested, then applied only once both live lines idle.
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   tx_host/rx_host host-side serial lines
//   ch_rx/ch_tx     per-channel serial lines (unselected ch_tx held at 1)
//   sel_req/_valid  channel request, accepted when sel_ready is high
//   active_sel      channel currently routed
//   switching       a switch is pending (DRAIN or SWITCH)
//   sel_err         1-cycle pulse for an out-of-range request
//   drain_to        1-cycle pulse when a busy line forces the switch
// Macro UART_ROUTER_DRAIN_TIMEOUT_EN adds the DRAIN_TIMEOUT forced switch;
// without it DRAIN waits for idle forever and drain_to is tied 0.

module uart_channel_router #(
    parameter int N_CH          = 4,
    parameter int SEL_W         = $clog2(N_CH),
`ifdef UART_ROUTER_DRAIN_TIMEOUT_EN
    parameter int DRAIN_TIMEOUT = 4096,
`endif
    parameter int IDLE_CYCLES   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tx_host,
    output logic             rx_host,
    input  logic [N_CH-1:0]  ch_rx,
    output logic [N_CH-1:0]  ch_tx,
    input  logic [SEL_W-1:0] sel_req,
    input  logic             sel_valid,
    output logic             sel_ready,
    output logic [SEL_W-1:0] active_sel,
    output logic             switching,
    output logic             sel_err,
    output logic             drain_to
);

    localparam int IW  = $clog2(IDLE_CYCLES + 1);
    localparam int SW1 = SEL_W + 1;
    localparam logic [IW-1:0]  IDLE_MAX = IW'(IDLE_CYCLES);
    localparam logic [SEL_W:0] NCH_LIM  = SW1'(N_CH);

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_SWITCH = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [1:0]       tx_sync_q;
    logic [N_CH-1:0]  rx_s1_q;
    logic [N_CH-1:0]  rx_s2_q;
    logic             tx_line;
    logic             rx_line;
    logic             line_high;
    logic             line_idle;
    logic [IW-1:0]    idle_cnt_q, idle_cnt_d;
    logic [SEL_W-1:0] active_sel_q, active_sel_d;
    logic [SEL_W-1:0] pend_sel_q, pend_sel_d;
    logic [N_CH-1:0]  ch_tx_q, ch_tx_d;
    logic             rx_host_q, rx_host_d;
    logic             sel_err_q, sel_err_d;
    logic             accept;
    logic             req_bad;
    logic             req_same;
    logic             drain_expired;

    // Synchronisers preset to mark so reset looks like an idle line.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_sync_q <= 2'b11;
            rx_s1_q   <= '1;
            rx_s2_q   <= '1;
        end else begin
            tx_sync_q <= {tx_sync_q[0], tx_host};
            rx_s1_q   <= ch_rx;
            rx_s2_q   <= rx_s1_q;
        end
    end

    assign tx_line   = tx_sync_q[1];
    assign rx_line   = rx_s2_q[active_sel_q];
    assign line_high = tx_line & rx_line;
    assign line_idle = (idle_cnt_q == IDLE_MAX);

    // Saturating run length of both live lines at mark; the SWITCH
    // cycle restarts it so the new channel must prove idle on its own.
    always_comb begin
        idle_cnt_d = '0;
        if (state_q != ST_SWITCH && line_high) begin
            idle_cnt_d = line_idle ? idle_cnt_q : idle_cnt_q + 1'b1;
        end
    end

    assign req_bad  = ({1'b0, sel_req} >= NCH_LIM);
    assign req_same = (sel_req == active_sel_q);
    assign accept   = sel_valid & sel_ready;

`ifdef UART_ROUTER_DRAIN_TIMEOUT_EN
    localparam int DW = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_TIMEOUT - 1);

    logic [DW-1:0] drain_cnt_q, drain_cnt_d;
    logic          drain_to_q, drain_to_d;

    // Counts DRAIN cycles; the last one forces the move to SWITCH.
    assign drain_expired = (state_q == ST_DRAIN) &&
                           (drain_cnt_q == DRAIN_LAST);
    assign drain_to_d    = drain_expired & ~line_idle;

    always_comb begin
        drain_cnt_d = '0;
        if (state_q == ST_DRAIN && !drain_expired) begin
            drain_cnt_d = drain_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drain_cnt_q <= '0;
            drain_to_q  <= 1'b0;
        end else begin
            drain_cnt_q <= drain_cnt_d;
            drain_to_q  <= drain_to_d;
        end
    end

    assign drain_to = drain_to_q;
`else
    assign drain_expired = 1'b0;
    assign drain_to      = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_ACTIVE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_ACTIVE: begin
                if (accept && !req_bad && !req_same) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (line_idle || drain_expired) begin
                    state_d = ST_SWITCH;
                end
            end
            ST_SWITCH: state_d = ST_ACTIVE;
            default:   state_d = ST_ACTIVE;
        endcase
    end

    // FSM outputs
    always_comb begin
        sel_ready = (state_q == ST_ACTIVE);
        switching = (state_q == ST_DRAIN) || (state_q == ST_SWITCH);
    end

    // Request bookkeeping
    always_comb begin
        active_sel_d = active_sel_q;
        pend_sel_d   = pend_sel_q;
        sel_err_d    = 1'b0;
        if (state_q == ST_SWITCH) begin
            active_sel_d = pend_sel_q;
        end
        if (accept) begin
            if (req_bad) begin
                sel_err_d = 1'b1;
            end else if (!req_same) begin
                pend_sel_d = sel_req;
            end
        end
    end

    // Routing: the SWITCH cycle drives mark everywhere so no glitch of
    // the old channel leaks onto the new one.
    always_comb begin
        ch_tx_d   = '1;
        rx_host_d = 1'b1;
        if (state_q != ST_SWITCH) begin
            ch_tx_d[active_sel_q] = tx_line;
            rx_host_d             = rx_line;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idle_cnt_q   <= '0;
            active_sel_q <= '0;
            pend_sel_q   <= '0;
            ch_tx_q      <= '1;
            rx_host_q    <= 1'b1;
            sel_err_q    <= 1'b0;
        end else begin
            idle_cnt_q   <= idle_cnt_d;
            active_sel_q <= active_sel_d;
            pend_sel_q   <= pend_sel_d;
            ch_tx_q      <= ch_tx_d;
            rx_host_q    <= rx_host_d;
            sel_err_q    <= sel_err_d;
        end
    end

    assign ch_tx      = ch_tx_q;
    assign rx_host    = rx_host_q;
    assign active_sel = active_sel_q;
    assign sel_err    = sel_err_q;

endmodule
